// File: rtl/note_scroll_scheduler.sv
// Per-frame scroll-step sequencer: latches note speed at frame start and issues 1-3 steps.
// Optional SPEED_RAMP_EN: cur_speed moves at most one level toward the request per frame.
module note_scroll_scheduler #(
  parameter int POS_W       = 10,
  parameter int PX_PER_STEP = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       note_speed,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic             step_ready,
  input  logic             clr_overrun,
  output logic             step_valid,
  output logic             busy,
  output logic [1:0]       cur_speed,
  output logic [POS_W-1:0] scroll_pos,
  output logic             frame_done,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [POS_W-1:0] STEP = POS_W'(PX_PER_STEP);

  logic [1:0]       state_q, state_d;
  logic [1:0]       speed_q, speed_d;
  logic [1:0]       rem_q, rem_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       req_spd;
  logic [1:0]       tgt_spd;
  logic             xfer;
  logic             lost;

  assign req_spd = (note_speed == 2'd0) ? 2'd1 : note_speed;

`ifdef SPEED_RAMP_EN
  always_comb begin
    tgt_spd = speed_q;
    if (speed_q < req_spd)
      tgt_spd = speed_q + 2'd1;
    else if (speed_q > req_spd)
      tgt_spd = speed_q - 2'd1;
  end
`else
  assign tgt_spd = req_spd;
`endif

  assign step_valid = (state_q == S_ISSUE);
  assign busy       = (state_q == S_ISSUE);
  assign frame_done = (state_q == S_DONE);
  assign cur_speed  = speed_q;
  assign scroll_pos = pos_q;
  assign overrun    = ovr_q;
  assign xfer       = step_valid && step_ready;

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    pos_d   = pos_q;
    lost    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick || pend_q) begin
          speed_d = tgt_spd;
          // a tick arriving with a queued frame is kept for the next one
          pend_d  = pend_q && frame_tick;
          if (pause) begin
            state_d = S_DONE;
          end else begin
            rem_d   = tgt_spd;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          pos_d = pos_q + STEP;
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_q != S_IDLE && frame_tick) begin
      if (pend_q)
        lost = 1'b1;
      else
        pend_d = 1'b1;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (lost)
      ovr_d = 1'b1;
    else if (clr_overrun)
      ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      speed_q <= 2'd1;
      rem_q   <= 2'd0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      pos_q   <= pos_d;
    end
  end

endmodule

// File: tb/tb_note_scroll_scheduler.sv
// Scoreboard bench for note_scroll_scheduler: frame-level expectations queued
// at frame start, popped by a monitor on each frame_done.
module tb_note_scroll_scheduler;

  localparam int POS_W = 4;
  localparam int PX    = 1;
  localparam int MODN  = 1 << POS_W;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [1:0]       note_speed = 2'd1;
  logic             frame_tick = 1'b0;
  logic             pause = 1'b0;
  logic             step_ready = 1'b0;
  logic             clr_overrun = 1'b0;
  logic             step_valid;
  logic             busy;
  logic [1:0]       cur_speed;
  logic [POS_W-1:0] scroll_pos;
  logic             frame_done;
  logic             overrun;

  note_scroll_scheduler #(.POS_W(POS_W), .PX_PER_STEP(PX)) dut (
    .clk(clk), .resetn(resetn), .note_speed(note_speed),
    .frame_tick(frame_tick), .pause(pause), .step_ready(step_ready),
    .clr_overrun(clr_overrun), .step_valid(step_valid), .busy(busy),
    .cur_speed(cur_speed), .scroll_pos(scroll_pos),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int spd;
    int n;
    int pos;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int last_n = -1;
  int cnt = 0;
  bit pv = 0;
  bit pr = 0;

  // frame-level reference: 0 idle, 1 issuing, 2 done-cycle
  int m_mode = 0;
  int m_left = 0;
  int m_cur = 1;
  int m_pos = 0;
  bit m_pend = 0;
  bit m_ovr = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int next_speed(int cur, int s);
    int c;
    c = (s == 0) ? 1 : s;
`ifdef SPEED_RAMP_EN
    if (cur < c) return cur + 1;
    if (cur > c) return cur - 1;
    return cur;
`else
    return c;
`endif
  endfunction

  task automatic model_step(bit tk, int spd, bit ps, bit rdy, bit clr);
    bit lost;
    int n;
    lost = 0;
    if (m_mode == 0) begin
      if (tk || m_pend) begin
        m_pend = m_pend && tk;
        m_cur = next_speed(m_cur, spd);
        n = ps ? 0 : m_cur;
        q.push_back('{m_cur, n, (m_pos + n * PX) % MODN});
        if (ps) m_mode = 2;
        else begin
          m_left = m_cur;
          m_mode = 1;
        end
      end
    end else begin
      if (tk) begin
        if (m_pend) lost = 1;
        else m_pend = 1;
      end
      if (m_mode == 1) begin
        if (rdy) begin
          m_pos = (m_pos + PX) % MODN;
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
      end else begin
        m_mode = 0;
      end
    end
    if (lost) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic cyc(bit tk, int spd, bit ps, bit rdy, bit clr);
    frame_tick = tk;
    note_speed = 2'(spd);
    pause = ps;
    step_ready = rdy;
    clr_overrun = clr;
    @(posedge clk);
    #1;
    if (resetn) model_step(tk, spd, ps, rdy, clr);
    frame_tick = 1'b0;
    clr_overrun = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    frame_tick = 1'b0;
    clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    m_mode = 0; m_left = 0; m_cur = 1; m_pos = 0;
    m_pend = 0; m_ovr = 0;
    q.delete();
  endtask

  task automatic run_frame(int spd, bit ps);
    int k;
    k = 0;
    cyc(1, spd, ps, 1, 0);
    while (m_mode != 0 && k < 50) begin
      cyc(0, spd, ps, 1, 0);
      k++;
    end
    chk("frame_timeout", m_mode, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_mode != 0 || m_pend) && k < 100) begin
      cyc(0, 1, 0, 1, 0);
      k++;
    end
    cyc(0, 1, 0, 1, 0);
    chk("drain_timeout", (m_mode != 0 || m_pend) ? 1 : 0, 0);
    chk("queue_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      cnt = 0;
      pv = 0;
      pr = 0;
    end else begin
      if (pv && !pr) chk("valid_held", int'(step_valid), 1);
      chk("busy_eq_valid", int'(busy), int'(step_valid));
      chk("valid_model", int'(step_valid), (m_mode == 1) ? 1 : 0);
      chk("done_model", int'(frame_done), (m_mode == 2) ? 1 : 0);
      chk("pos_model", int'(scroll_pos), m_pos);
      chk("ovr_model", int'(overrun), int'(m_ovr));
      if (step_valid && step_ready) cnt++;
      if (frame_done) begin
        if (q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("frame_steps", cnt, e.n);
          chk("frame_speed", int'(cur_speed), e.spd);
          chk("frame_pos", int'(scroll_pos), e.pos);
          last_n = cnt;
        end
        cnt = 0;
      end
      pv = step_valid;
      pr = step_ready;
    end
  end

  initial begin
    do_reset();
    repeat (10) cyc(0, 1, 0, 0, 0);
    chk("rst_valid", int'(step_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_speed", int'(cur_speed), 1);
    chk("rst_pos", int'(scroll_pos), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_ovr", int'(overrun), 0);

    cyc(1, 2, 0, 1, 0);
    chk("x2_valid1", int'(step_valid), 1);
    cyc(0, 2, 0, 1, 0);
    chk("x2_valid2", int'(step_valid), 1);
    cyc(0, 2, 0, 1, 0);
    chk("x2_done", int'(frame_done), 1);
    chk("x2_pos", int'(scroll_pos), 2);
    chk("x2_speed", int'(cur_speed), 2);
    cyc(0, 2, 0, 1, 0);

    cyc(1, 3, 0, 0, 0);
    repeat (4) begin
      chk("bp_valid", int'(step_valid), 1);
      cyc(0, 3, 0, 0, 0);
    end
    repeat (3) cyc(0, 3, 0, 1, 0);
    chk("bp_done", int'(frame_done), 1);
`ifndef SPEED_RAMP_EN
    chk("bp_pos", int'(scroll_pos), 5);
`endif
    cyc(0, 3, 0, 1, 0);

    cyc(1, 2, 1, 1, 0);
    chk("pause_done", int'(frame_done), 1);
    chk("pause_valid", int'(step_valid), 0);
    chk("pause_speed", int'(cur_speed), 2);
    cyc(0, 2, 0, 1, 0);
    run_frame(0, 0);
    chk("clamp_steps", last_n, 1);

    cyc(1, 3, 0, 0, 0);
    cyc(0, 3, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    cyc(0, 3, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    chk("ovr_set", int'(overrun), 1);
    cyc(1, 3, 0, 0, 1);
    chk("ovr_set_wins", int'(overrun), 1);
    cyc(0, 3, 0, 0, 1);
    chk("ovr_clr", int'(overrun), 0);
    drain();

    do_reset();
    repeat (17) run_frame(1, 0);
    chk("wrap_pos", int'(scroll_pos), 1);

    run_frame(1, 0);
    run_frame(3, 0);
`ifdef SPEED_RAMP_EN
    chk("ramp_first", last_n, 2);
    run_frame(3, 0);
    chk("ramp_second", last_n, 3);
`else
    chk("jump_first", last_n, 3);
`endif

    cyc(1, 3, 0, 0, 0);
    cyc(0, 3, 0, 0, 0);
    do_reset();
    #4;
    chk("midrst_valid", int'(step_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_speed", int'(cur_speed), 1);
    chk("midrst_pos", int'(scroll_pos), 0);

    repeat (3000) begin
      cyc($urandom_range(0, 5) == 0, int'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 15) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_scroll_scheduler.md
Name: note_scroll_scheduler

Overview:
- Per-frame sequencer for note falling motion.
- On each frame tick it latches the selected note speed (1x/2x/3x) and issues that many scroll-step requests to the note-field updater over a valid/ready handshake.
- It also keeps the running scroll position.
- Sits between the speed switch decoder (note_speed) and the note renderer/updater; speed changes take effect only at frame boundaries.

Parameters:
- POS_W, 10, width of scroll_pos counter.
- PX_PER_STEP, 1, pixels added to scroll_pos per accepted step; must be below 2^POS_W.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- note_speed  input  2  requested speed: 1, 2 or 3; value 0 treated as 1
- frame_tick  input  1  one-cycle pulse per video frame
- pause  input  1  level; sampled only when a frame starts
- step_ready  input  1  updater accepts step
- step_valid  output  1  step request
- busy  output  1  high while a frame's steps are outstanding
- cur_speed  output  2  speed latched for current/last frame
- scroll_pos  output  POS_W  running scroll offset
- frame_done  output  1  one-cycle pulse at end of each frame's sequence
- overrun  output  1  sticky: frame tick lost
- clr_overrun  input  1  clears overrun

Behaviour:
- Reset (resetn=0 at posedge), applies mid-operation too, no step completion:
  - step_valid=0, busy=0, cur_speed=1, scroll_pos=0, frame_done=0, overrun=0.
  - Internal pending=0, remaining=0, state=IDLE.
- States: IDLE, ISSUE, DONE.
- IDLE, frame start (frame_tick=1, or pending=1):
  - Latch cur_speed from clamped note_speed; clear pending.
  - If pause=0: remaining=cur_speed, go to ISSUE; step_valid and busy are high from the next cycle (latency 1).
  - If pause=1: no steps; go to DONE.
- ISSUE:
  - step_valid held high until step_ready. A transfer occurs on a cycle with step_valid&&step_ready.
  - Each transfer: scroll_pos += PX_PER_STEP, modulo 2^POS_W (wraps silently); remaining decrements.
  - If remaining>1 before the transfer, step_valid stays high (back-to-back steps allowed, one per cycle max).
  - If the transfer was the last step: step_valid drops next cycle, go to DONE.
  - step_valid never deasserts without a transfer.
  - pause changes during ISSUE are ignored.
- DONE (exactly one cycle):
  - frame_done=1, busy=0.
  - Next state IDLE; if pending=1, the next frame starts in the IDLE cycle that follows.
- frame_tick while in ISSUE or DONE:
  - If pending=0: set pending=1.
  - If pending=1: set overrun=1; the tick is dropped.
- clr_overrun clears overrun. If clr_overrun coincides with a new overrun event, set wins.
- note_speed changes mid-frame have no effect until the next frame start.
- busy is high in ISSUE only.
- Maximum throughput: 3 steps per frame, complete in 3 cycles if step_ready is held high.

Optional Feature:
- Macro SPEED_RAMP_EN.
- Defined: at each frame start, cur_speed moves by at most 1 toward the clamped note_speed (e.g., 1 to 3 takes two frames: 2, then 3). Step count per frame equals the ramped cur_speed.
- Not defined: cur_speed jumps directly to the clamped note_speed at the frame start.

Test Plan:
- Reset and idle: resetn low 2 cycles, then idle 10 cycles -> step_valid=0, busy=0, cur_speed=1, scroll_pos=0, overrun=0.
- 2x speed: note_speed=2, step_ready=1, frame_tick pulse at cycle t -> step_valid high at t+1 and t+2, frame_done at t+3, scroll_pos=2, cur_speed=2.
- Backpressure: note_speed=3, step_ready low 4 cycles then high -> step_valid held high throughout, exactly 3 transfers, scroll_pos=3, one frame_done.
- Pause and clamp:
  - pause=1 at frame_tick -> no step_valid, frame_done one cycle later, cur_speed updated.
  - note_speed=0 with pause=0 -> exactly 1 step.
- Overrun and pending: step_ready=0, speed 3, two further frame_ticks during ISSUE -> overrun=1 after the second extra tick. Release step_ready -> 3 steps, frame_done, then pending frame runs 3 more steps.
  - clr_overrun pulse -> overrun=0.
  - clr_overrun simultaneous with a lost tick -> overrun stays 1.
- Wrap and ramp:
  - POS_W=4, PX_PER_STEP=1, 17 steps -> scroll_pos=1.
  - With SPEED_RAMP_EN, speed 1 to 3 -> frames issue 2 then 3 steps.
  - Without SPEED_RAMP_EN, speed 1 to 3 -> 3 steps on the first frame.
